// File: rtl/feeder_timing_core_pkg.sv
// Shared definitions for the pet feeder timing core: option codes and
// default sizing for the pour length, interval sum and interval counter.
package feeder_timing_core_pkg;

   typedef enum logic [2:0] {
      OPT_IDLE      = 3'd0,
      OPT_POUR_FOOD = 3'd1,
      OPT_STOP_FOOD = 3'd2,
      OPT_INTERVAL  = 3'd3,
      OPT_RESET     = 3'd4
   } option_e;

   localparam int FOOD_CYCLES_DEF = 10;
   localparam int SUM_W_DEF       = 16;
   localparam int ICNT_W_DEF      = 21;

endpackage

// File: rtl/feeder_timing_core_if.sv
// Control/status bundle between the option FSM (master) and the timing core (slave).
interface feeder_timing_core_if
   import feeder_timing_core_pkg::*;
#(
   parameter int SUM_W  = SUM_W_DEF,
   parameter int ICNT_W = ICNT_W_DEF
);
   logic [3:0]        keyboard_digit;
   logic              digit_enable;
   logic [2:0]        keyboard_option;
   logic              count_enable;
   logic              count_reset;
   logic              interval_enable;
   logic              interval_reset;
   logic [SUM_W-1:0]  interval;
   logic [3:0]        food_count;
   logic [ICNT_W-1:0] interval_count;
   logic              switch_f_c;
   logic              switch_i_c;
   logic              food_switch;

   modport master (
      output keyboard_digit, digit_enable, keyboard_option,
             count_enable, count_reset, interval_enable, interval_reset,
      input  interval, food_count, interval_count,
             switch_f_c, switch_i_c, food_switch
   );

   modport slave (
      input  keyboard_digit, digit_enable, keyboard_option,
             count_enable, count_reset, interval_enable, interval_reset,
      output interval, food_count, interval_count,
             switch_f_c, switch_i_c, food_switch
   );
endinterface

// File: rtl/feeder_timing_core_period_counter.sv
// Periodic pour timer: counts 0..FOOD_CYCLES+interval-1, active for the first FOOD_CYCLES counts.
module feeder_timing_core_period_counter
   import feeder_timing_core_pkg::*;
#(
   parameter int FOOD_CYCLES = FOOD_CYCLES_DEF,
   parameter int SUM_W       = SUM_W_DEF,
   parameter int ICNT_W      = ICNT_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable,
   input  logic              clear,
   input  logic [SUM_W-1:0]  interval,
   output logic [ICNT_W-1:0] count,
   output logic              active
);
   logic              interval_nz;
   logic [ICNT_W-1:0] period_last;

   assign interval_nz = |interval;
   assign period_last = ICNT_W'(interval) + ICNT_W'(FOOD_CYCLES - 1);

   // >= rather than == so a shrunken interval mid-run still wraps to 0
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable && interval_nz)
         count <= (count >= period_last) ? '0 : count + ICNT_W'(1);
   end

   assign active = reset & enable & interval_nz & (count < ICNT_W'(FOOD_CYCLES));
endmodule

// File: rtl/feeder_timing_core.sv
// Pet feeder timing core: saturating digit accumulator, single-pour food
// counter, periodic interval counter and the food_switch output decode.
module feeder_timing_core
   import feeder_timing_core_pkg::*;
#(
   parameter int FOOD_CYCLES = FOOD_CYCLES_DEF,
   parameter int SUM_W       = SUM_W_DEF,
   parameter int ICNT_W      = ICNT_W_DEF
) (
   input logic                 clock,
   input logic                 reset,
   feeder_timing_core_if.slave bus
);
   logic [SUM_W-1:0]  interval_r;
   logic [3:0]        food_count_r;
   logic [ICNT_W-1:0] interval_count_w;
   logic              switch_f_c_w;
   logic              switch_i_c_w;

   function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                                input logic [3:0]       d);
      logic [SUM_W:0] s;
      s = {1'b0, a} + {{(SUM_W-3){1'b0}}, d};
      return s[SUM_W] ? {SUM_W{1'b1}} : s[SUM_W-1:0];
   endfunction

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         interval_r <= '0;
      else if (bus.digit_enable)
         interval_r <= sat_add(interval_r, bus.keyboard_digit);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         food_count_r <= '0;
      else if (bus.count_reset)
         food_count_r <= '0;
      else if (bus.count_enable && (food_count_r < 4'(FOOD_CYCLES)))
         food_count_r <= food_count_r + 4'd1;
   end

   // Gated by reset so the actuator is off while reset is held, even with enables high
   assign switch_f_c_w = reset & bus.count_enable & (food_count_r < 4'(FOOD_CYCLES));

   feeder_timing_core_period_counter #(
      .FOOD_CYCLES (FOOD_CYCLES),
      .SUM_W       (SUM_W),
      .ICNT_W      (ICNT_W)
   ) u_period_counter (
      .clock    (clock),
      .reset    (reset),
      .enable   (bus.interval_enable),
      .clear    (bus.interval_reset),
      .interval (interval_r),
      .count    (interval_count_w),
      .active   (switch_i_c_w)
   );

   assign bus.interval       = interval_r;
   assign bus.food_count     = food_count_r;
   assign bus.interval_count = interval_count_w;
   assign bus.switch_f_c     = switch_f_c_w;
   assign bus.switch_i_c     = switch_i_c_w;
   assign bus.food_switch    = ((bus.keyboard_option == OPT_POUR_FOOD) & switch_f_c_w) |
                               ((bus.keyboard_option == OPT_INTERVAL)  & switch_i_c_w);
endmodule

// File: tb/tb_feeder_timing_core.sv
// Directed bench for feeder_timing_core with hand-computed expectations.
module tb_feeder_timing_core;
   logic clock;
   logic reset;
   int   n_cmp;
   int   n_err;
   int   ones;

   feeder_timing_core_if #(.SUM_W(16), .ICNT_W(21)) bus ();

   feeder_timing_core #(
      .FOOD_CYCLES (10),
      .SUM_W       (16),
      .ICNT_W      (21)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic pour20();
      ones = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         chk("pour_cnt", 32'(bus.food_count), (i < 10) ? i : 10);
         if (bus.food_switch) ones++;
         step();
      end
      chk("pour_len", ones, 10);
      chk("pour_stop", 32'(bus.food_count), 10);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b0;
      bus.keyboard_digit  = 4'd0;
      bus.digit_enable    = 1'b0;
      bus.keyboard_option = 3'd0;
      bus.count_enable    = 1'b0;
      bus.count_reset     = 1'b0;
      bus.interval_enable = 1'b0;
      bus.interval_reset  = 1'b0;
      #2;
      chk("rst_interval", 32'(bus.interval), 0);
      chk("rst_food", 32'(bus.food_count), 0);
      chk("rst_icnt", 32'(bus.interval_count), 0);
      chk("rst_switch", 32'(bus.food_switch), 0);
      #11 reset = 1'b1;
      step();

      // interval == 0 in INTERVAL mode never pours
      bus.keyboard_option = 3'd3;
      bus.interval_enable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("zero_iv_sw", 32'(bus.food_switch), 0);
         step();
      end
      chk("zero_iv_hold", 32'(bus.interval_count), 0);
      bus.interval_enable = 1'b0;
      bus.keyboard_option = 3'd0;

      // digit accumulation 3, 9, 15
      bus.digit_enable = 1'b1;
      bus.keyboard_digit = 4'd3;  step(); chk("acc_3", 32'(bus.interval), 3);
      bus.keyboard_digit = 4'd9;  step(); chk("acc_12", 32'(bus.interval), 12);
      bus.keyboard_digit = 4'd15; step(); chk("acc_27", 32'(bus.interval), 27);
      bus.digit_enable = 1'b0;
      step();
      chk("acc_hold", 32'(bus.interval), 27);

      // manual pours
      bus.keyboard_option = 3'd1;
      bus.count_enable = 1'b1;
      pour20();
      bus.count_reset = 1'b1;
      step();
      chk("creset_win", 32'(bus.food_count), 0);
      chk("creset_iv", 32'(bus.interval), 27);
      bus.count_reset = 1'b0;
      pour20();

      // stop mid-pour
      bus.count_reset = 1'b1;
      step();
      bus.count_reset = 1'b0;
      repeat (4) step();
      chk("stop_cnt", 32'(bus.food_count), 4);
      chk("stop_pre", 32'(bus.food_switch), 1);
      bus.keyboard_option = 3'd2;
      #1;
      chk("stop_sw", 32'(bus.food_switch), 0);
      chk("stop_fc", 32'(bus.switch_f_c), 1);
      bus.count_enable = 1'b0;
      bus.count_reset = 1'b1;
      step();
      chk("stop_clr", 32'(bus.food_count), 0);
      bus.count_reset = 1'b0;

      // async reset mid-run
      bus.keyboard_option = 3'd1;
      bus.count_enable = 1'b1;
      bus.interval_enable = 1'b1;
      repeat (3) step();
      chk("mid_fc", 32'(bus.food_count), 3);
      chk("mid_ic", 32'(bus.interval_count), 3);
      reset = 1'b0;
      #1;
      chk("arst_iv", 32'(bus.interval), 0);
      chk("arst_fc", 32'(bus.food_count), 0);
      chk("arst_ic", 32'(bus.interval_count), 0);
      chk("arst_sfc", 32'(bus.switch_f_c), 0);
      chk("arst_sw", 32'(bus.food_switch), 0);
      bus.count_enable = 1'b0;
      bus.interval_enable = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("rel_iv", 32'(bus.interval), 0);
      chk("rel_sw", 32'(bus.food_switch), 0);
      step();

      // interval mode with interval = 5: 10 on, 5 off
      bus.keyboard_digit = 4'd5;
      bus.digit_enable = 1'b1;
      step();
      bus.digit_enable = 1'b0;
      chk("iv_5", 32'(bus.interval), 5);
      bus.keyboard_option = 3'd3;
      bus.interval_enable = 1'b1;
      ones = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         chk("iv_cnt", 32'(bus.interval_count), i % 15);
         chk("iv_sw", 32'(bus.food_switch), ((i % 15) < 10) ? 1 : 0);
         if (bus.food_switch) ones++;
         step();
      end
      chk("iv_ones", ones, 30);
      repeat (5) step();
      chk("iv_wrap", 32'(bus.interval_count), 0);

      // IDLE option masks a running periodic pour
      bus.keyboard_option = 3'd0;
      #1;
      chk("idle_sic", 32'(bus.switch_i_c), 1);
      chk("idle_sw", 32'(bus.food_switch), 0);

      // interval_reset beats interval_enable
      repeat (2) step();
      chk("ir_pre", 32'(bus.interval_count), 2);
      bus.interval_reset = 1'b1;
      step();
      chk("ir_win", 32'(bus.interval_count), 0);
      chk("ir_iv", 32'(bus.interval), 5);
      bus.interval_reset = 1'b0;
      bus.interval_enable = 1'b0;

      // saturation: 5 + 4368*15 + 9 = 0xFFFE, then +5 and +15 clamp
      bus.digit_enable = 1'b1;
      bus.keyboard_digit = 4'd15;
      repeat (4368) step();
      bus.keyboard_digit = 4'd9;
      step();
      chk("sat_fffe", 32'(bus.interval), 32'hFFFE);
      bus.keyboard_digit = 4'd5;
      step();
      chk("sat_ffff", 32'(bus.interval), 32'hFFFF);
      bus.keyboard_digit = 4'd15;
      step();
      chk("sat_hold", 32'(bus.interval), 32'hFFFF);
      bus.digit_enable = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
